// File: rtl/char_grid_buf_if.sv
// rtl/char_grid_buf_if.sv - ready/valid byte stream feeding the character grid buffer
interface char_grid_buf_if #(
    parameter int p_attr_bits = 4
);
    logic [7:0]             in_ascii;
    logic [p_attr_bits-1:0] in_attr;
    logic                   in_val;
    logic                   in_rdy;

    modport master (output in_ascii, output in_attr, output in_val, input in_rdy);
    modport slave  (input in_ascii, input in_attr, input in_val, output in_rdy);
endinterface

// File: rtl/char_grid_buf.sv
// rtl/char_grid_buf.sv - scrolling ASCII+attribute text grid with clear sequencer and blinking cursor
module char_grid_buf #(
    parameter int p_num_rows     = 16,
    parameter int p_num_cols     = 32,
    parameter int p_attr_bits    = 4,
    parameter int p_tab_width    = 4,
    parameter int p_blink_cycles = 12500000,
    localparam int lc_cw = $clog2(p_num_cols),
    localparam int lc_rw = $clog2(p_num_rows)
) (
    input  logic                   clk,
    input  logic                   rst,
    char_grid_buf_if.slave         in_if,
    input  logic [7:0]             rd_hchar,
    input  logic [7:0]             rd_vchar,
    output logic [7:0]             rd_char,
    output logic [p_attr_bits-1:0] rd_attr,
    output logic                   rd_cursor,
    output logic                   rd_oob,
    output logic [lc_cw-1:0]       cursor_x,
    output logic [lc_rw-1:0]       cursor_y
);
    localparam int lc_bw     = $clog2(p_blink_cycles);
    localparam int lc_cell_w = 8 + p_attr_bits;

    localparam logic [lc_cw-1:0] lc_last_col   = lc_cw'(p_num_cols - 1);
    localparam logic [lc_rw-1:0] lc_last_row   = lc_rw'(p_num_rows - 1);
    localparam logic [lc_cw:0]   lc_tab_mask   = (lc_cw+1)'(p_tab_width - 1);
    localparam logic [lc_cw:0]   lc_tab_one    = (lc_cw+1)'(1);
    localparam logic [lc_cw:0]   lc_tab_wrap   = (lc_cw+1)'(p_num_cols);
    localparam logic [lc_bw-1:0] lc_blink_last = lc_bw'(p_blink_cycles - 1);
    localparam logic [8:0]       lc_cols_lim   = 9'(p_num_cols);
    localparam logic [8:0]       lc_rows_lim   = 9'(p_num_rows);

    typedef enum logic {st_idle, st_clear} state_t;

    state_t                 state_q, state_d;
    logic [lc_rw-1:0]       row_cnt_q, row_cnt_d;
    logic [lc_cw-1:0]       cursor_x_q, cursor_x_d;
    logic [lc_rw-1:0]       cursor_y_q, cursor_y_d;
    logic [lc_rw-1:0]       top_q, top_d;
    logic [lc_bw-1:0]       blink_cnt_q, blink_cnt_d;
    logic                   blink_on_q, blink_on_d;
    logic [7:0]             rd_char_q, rd_char_d;
    logic [p_attr_bits-1:0] rd_attr_q, rd_attr_d;
    logic                   rd_cursor_q, rd_cursor_d;
    logic                   rd_oob_q, rd_oob_d;

    // Grid storage is never reset; the CLEAR sequence zeroes it row by row.
    logic [lc_cell_w-1:0]   grid_mem [p_num_rows][p_num_cols];

    logic                   accept;
    logic                   do_nl;
    logic [lc_rw-1:0]       cur_row;
    logic [lc_cw:0]         tab_next;
    logic                   wr_en;
    logic [lc_rw-1:0]       wr_row;
    logic [lc_cw-1:0]       wr_col;
    logic [lc_cell_w-1:0]   wr_data;
    logic                   clr_en;
    logic [lc_rw-1:0]       clr_row;
    logic [lc_rw-1:0]       rd_row;
    logic [lc_cw-1:0]       rd_col;
    logic [lc_cell_w-1:0]   rd_cell;

    assign accept   = in_if.in_val && (state_q == st_idle);
    assign cur_row  = cursor_y_q + top_q;
    assign tab_next = ({1'b0, cursor_x_q} | lc_tab_mask) + lc_tab_one;

    always_comb begin
        state_d     = state_q;
        row_cnt_d   = row_cnt_q;
        cursor_x_d  = cursor_x_q;
        cursor_y_d  = cursor_y_q;
        top_d       = top_q;
        blink_cnt_d = blink_cnt_q;
        blink_on_d  = blink_on_q;
        wr_en       = 1'b0;
        wr_row      = cur_row;
        wr_col      = cursor_x_q;
        wr_data     = '0;
        clr_en      = 1'b0;
        clr_row     = row_cnt_q;
        do_nl       = 1'b0;

        if (state_q == st_clear) begin
            clr_en  = 1'b1;
            clr_row = row_cnt_q;
            if (row_cnt_q == lc_last_row) begin
                state_d   = st_idle;
                row_cnt_d = '0;
            end else begin
                row_cnt_d = row_cnt_q + lc_rw'(1);
            end
        end else if (accept) begin
            if (in_if.in_ascii == 8'h1B) begin
                cursor_x_d = '0;
                cursor_y_d = '0;
                top_d      = '0;
                row_cnt_d  = '0;
                state_d    = st_clear;
            end else if (in_if.in_ascii == 8'h0A) begin
                cursor_x_d = '0;
                do_nl      = 1'b1;
            end else if (in_if.in_ascii == 8'h0D) begin
                cursor_x_d = '0;
            end else if (in_if.in_ascii == 8'h09) begin
                if (tab_next == lc_tab_wrap) begin
                    cursor_x_d = '0;
                    do_nl      = 1'b1;
                end else begin
                    cursor_x_d = tab_next[lc_cw-1:0];
                end
            end else if (in_if.in_ascii == 8'h08 || in_if.in_ascii == 8'h7F) begin
                if (cursor_x_q != '0) begin
                    cursor_x_d = cursor_x_q - lc_cw'(1);
                    wr_en      = 1'b1;
                    wr_col     = cursor_x_q - lc_cw'(1);
                    wr_data    = '0;
                end
            end else if (in_if.in_ascii >= 8'h20 && in_if.in_ascii <= 8'h7E) begin
                wr_en   = 1'b1;
                wr_data = {in_if.in_ascii, in_if.in_attr};
                if (cursor_x_q == lc_last_col) begin
                    cursor_x_d = '0;
                    do_nl      = 1'b1;
                end else begin
                    cursor_x_d = cursor_x_q + lc_cw'(1);
                end
            end
        end

        // On the bottom line a newline scrolls: the old top row becomes the new bottom and is blanked.
        if (do_nl) begin
            if (cursor_y_q != lc_last_row) begin
                cursor_y_d = cursor_y_q + lc_rw'(1);
            end else begin
                top_d   = top_q + lc_rw'(1);
                clr_en  = 1'b1;
                clr_row = top_q;
            end
        end

        if (accept) begin
            blink_cnt_d = '0;
            blink_on_d  = 1'b1;
        end else if (blink_cnt_q == lc_blink_last) begin
            blink_cnt_d = '0;
            blink_on_d  = ~blink_on_q;
        end else begin
            blink_cnt_d = blink_cnt_q + lc_bw'(1);
        end
    end

    assign rd_row  = rd_vchar[lc_rw-1:0] + top_q;
    assign rd_col  = rd_hchar[lc_cw-1:0];
    assign rd_cell = grid_mem[rd_row][rd_col];

    always_comb begin
        rd_oob_d    = ({1'b0, rd_hchar} >= lc_cols_lim) || ({1'b0, rd_vchar} >= lc_rows_lim);
        rd_char_d   = '0;
        rd_attr_d   = '0;
        rd_cursor_d = 1'b0;
        if (!rd_oob_d && state_q == st_idle) begin
            rd_char_d   = rd_cell[lc_cell_w-1:p_attr_bits];
            rd_attr_d   = rd_cell[p_attr_bits-1:0];
            rd_cursor_d = blink_on_q && (rd_vchar[lc_rw-1:0] == cursor_y_q)
                          && (rd_hchar[lc_cw-1:0] == cursor_x_q);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= st_clear;
            row_cnt_q   <= '0;
            cursor_x_q  <= '0;
            cursor_y_q  <= '0;
            top_q       <= '0;
            blink_cnt_q <= '0;
            blink_on_q  <= 1'b1;
            rd_char_q   <= '0;
            rd_attr_q   <= '0;
            rd_cursor_q <= 1'b0;
            rd_oob_q    <= 1'b1;
        end else begin
            state_q     <= state_d;
            row_cnt_q   <= row_cnt_d;
            cursor_x_q  <= cursor_x_d;
            cursor_y_q  <= cursor_y_d;
            top_q       <= top_d;
            blink_cnt_q <= blink_cnt_d;
            blink_on_q  <= blink_on_d;
            rd_char_q   <= rd_char_d;
            rd_attr_q   <= rd_attr_d;
            rd_cursor_q <= rd_cursor_d;
            rd_oob_q    <= rd_oob_d;
        end
    end

    always_ff @(posedge clk) begin
        if (clr_en) begin
            for (int c = 0; c < p_num_cols; c++) begin
                grid_mem[clr_row][c] <= '0;
            end
        end
        if (wr_en) begin
            grid_mem[wr_row][wr_col] <= wr_data;
        end
    end

    assign in_if.in_rdy = (state_q == st_idle);
    assign rd_char      = rd_char_q;
    assign rd_attr      = rd_attr_q;
    assign rd_cursor    = rd_cursor_q;
    assign rd_oob       = rd_oob_q;
    assign cursor_x     = cursor_x_q;
    assign cursor_y     = cursor_y_q;
endmodule

// File: tb/tb_char_grid_buf.sv
// tb/tb_char_grid_buf.sv - directed self-checking bench for char_grid_buf
module tb_char_grid_buf;
    logic       clk;
    logic       rst;
    logic [7:0] rd_hchar;
    logic [7:0] rd_vchar;
    logic [7:0] rd_char;
    logic [3:0] rd_attr;
    logic       rd_cursor;
    logic       rd_oob;
    logic [4:0] cursor_x;
    logic [3:0] cursor_y;
    int         checks;
    int         failures;

    char_grid_buf_if #(.p_attr_bits(4)) in_if ();

    char_grid_buf #(
        .p_num_rows    (16),
        .p_num_cols    (32),
        .p_attr_bits   (4),
        .p_tab_width   (4),
        .p_blink_cycles(4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_if    (in_if),
        .rd_hchar (rd_hchar),
        .rd_vchar (rd_vchar),
        .rd_char  (rd_char),
        .rd_attr  (rd_attr),
        .rd_cursor(rd_cursor),
        .rd_oob   (rd_oob),
        .cursor_x (cursor_x),
        .cursor_y (cursor_y)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic send_byte(input logic [7:0] c, input logic [3:0] a);
        in_if.in_ascii = c;
        in_if.in_attr  = a;
        in_if.in_val   = 1'b1;
        @(posedge clk);
        #1;
        in_if.in_val   = 1'b0;
    endtask

    task automatic read_cell(input logic [7:0] v, input logic [7:0] h);
        rd_vchar = v;
        rd_hchar = h;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        int low_cnt;
        rst = 1'b1;
        in_if.in_val = 1'b0;
        rd_vchar = 8'd0;
        rd_hchar = 8'd0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (rd_oob !== 1'b1 || rd_char !== 8'h00 || rd_cursor !== 1'b0 || in_if.in_rdy !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs: oob=%b char=%h cur=%b rdy=%b, required oob=1 char=00 cur=0 rdy=0",
                     rd_oob, rd_char, rd_cursor, in_if.in_rdy);
        end
        checks++;
        if (cursor_x !== 5'd0 || cursor_y !== 4'd0) begin
            failures++;
            $display("FAIL reset_cursor: (%0d,%0d), required (0,0)", cursor_y, cursor_x);
        end
        rst = 1'b0;
        low_cnt = 0;
        for (int k = 0; k < 16; k++) begin
            if (in_if.in_rdy === 1'b0) low_cnt++;
            @(posedge clk);
            #1;
        end
        checks++;
        if (low_cnt != 16 || in_if.in_rdy !== 1'b1) begin
            failures++;
            $display("FAIL reset_clear_len: low cycles=%0d rdy_after=%b, required 16 and 1", low_cnt, in_if.in_rdy);
        end
        read_cell(8'd0, 8'd0);
        checks++;
        if (rd_char !== 8'h00 || rd_attr !== 4'h0 || rd_oob !== 1'b0) begin
            failures++;
            $display("FAIL reset_read00: char=%h attr=%h oob=%b, required 00 0 0", rd_char, rd_attr, rd_oob);
        end
    endtask

    task automatic test_write;
        send_byte(8'h41, 4'd3);
        send_byte(8'h42, 4'd5);
        read_cell(8'd0, 8'd2);
        checks++;
        if (rd_cursor !== 1'b1 || rd_char !== 8'h00 || cursor_x !== 5'd2 || cursor_y !== 4'd0) begin
            failures++;
            $display("FAIL write_cursor: cur=%b char=%h pos=(%0d,%0d), required 1 00 (0,2)",
                     rd_cursor, rd_char, cursor_y, cursor_x);
        end
        read_cell(8'd0, 8'd0);
        checks++;
        if (rd_char !== 8'h41 || rd_attr !== 4'd3 || rd_cursor !== 1'b0) begin
            failures++;
            $display("FAIL write_A: char=%h attr=%0d cur=%b, required 41 3 0", rd_char, rd_attr, rd_cursor);
        end
        read_cell(8'd0, 8'd1);
        checks++;
        if (rd_char !== 8'h42 || rd_attr !== 4'd5) begin
            failures++;
            $display("FAIL write_B: char=%h attr=%0d, required 42 5", rd_char, rd_attr);
        end
        rd_vchar = 8'd0;
        rd_hchar = 8'd2;
        send_byte(8'h43, 4'd7);
        checks++;
        if (rd_char !== 8'h00) begin
            failures++;
            $display("FAIL read_before_write: char=%h, required 00", rd_char);
        end
        read_cell(8'd0, 8'd2);
        checks++;
        if (rd_char !== 8'h43 || rd_attr !== 4'd7 || cursor_x !== 5'd3) begin
            failures++;
            $display("FAIL write_C: char=%h attr=%0d x=%0d, required 43 7 3", rd_char, rd_attr, cursor_x);
        end
    endtask

    task automatic test_wrap;
        send_byte(8'h0D, 4'd0);
        checks++;
        if (cursor_x !== 5'd0 || cursor_y !== 4'd0) begin
            failures++;
            $display("FAIL cr: (%0d,%0d), required (0,0)", cursor_y, cursor_x);
        end
        for (int i = 0; i < 32; i++) send_byte(8'h78, 4'd1);
        checks++;
        if (cursor_x !== 5'd0 || cursor_y !== 4'd1) begin
            failures++;
            $display("FAIL wrap_cursor: (%0d,%0d), required (1,0)", cursor_y, cursor_x);
        end
        send_byte(8'h79, 4'd2);
        read_cell(8'd1, 8'd0);
        checks++;
        if (rd_char !== 8'h79 || rd_attr !== 4'd2 || cursor_x !== 5'd1 || cursor_y !== 4'd1) begin
            failures++;
            $display("FAIL wrap_y: char=%h attr=%0d pos=(%0d,%0d), required 79 2 (1,1)",
                     rd_char, rd_attr, cursor_y, cursor_x);
        end
        read_cell(8'd0, 8'd31);
        checks++;
        if (rd_char !== 8'h78 || rd_attr !== 4'd1) begin
            failures++;
            $display("FAIL wrap_lastcol: char=%h attr=%0d, required 78 1", rd_char, rd_attr);
        end
        send_byte(8'h09, 4'd0);
        checks++;
        if (cursor_x !== 5'd4 || cursor_y !== 4'd1) begin
            failures++;
            $display("FAIL tab_first: (%0d,%0d), required (1,4)", cursor_y, cursor_x);
        end
        for (int i = 0; i < 6; i++) send_byte(8'h09, 4'd0);
        checks++;
        if (cursor_x !== 5'd28) begin
            failures++;
            $display("FAIL tab_to28: x=%0d, required 28", cursor_x);
        end
        send_byte(8'h09, 4'd0);
        checks++;
        if (cursor_x !== 5'd0 || cursor_y !== 4'd2) begin
            failures++;
            $display("FAIL tab_wrap: (%0d,%0d), required (2,0)", cursor_y, cursor_x);
        end
        read_cell(8'd1, 8'd4);
        checks++;
        if (rd_char !== 8'h00) begin
            failures++;
            $display("FAIL tab_nowrite: char=%h, required 00", rd_char);
        end
    endtask

    task automatic test_scroll;
        send_byte(8'h1B, 4'd0);
        repeat (16) @(posedge clk);
        #1;
        for (int i = 0; i < 16; i++) begin
            send_byte(8'h61 + 8'(i), 4'(i));
            send_byte(8'h0A, 4'd0);
        end
        checks++;
        if (cursor_x !== 5'd0 || cursor_y !== 4'd15) begin
            failures++;
            $display("FAIL scroll_cursor: (%0d,%0d), required (15,0)", cursor_y, cursor_x);
        end
        read_cell(8'd0, 8'd0);
        checks++;
        if (rd_char !== 8'h62 || rd_attr !== 4'd1) begin
            failures++;
            $display("FAIL scroll_top: char=%h attr=%0d, required 62 1", rd_char, rd_attr);
        end
        read_cell(8'd15, 8'd0);
        checks++;
        if (rd_char !== 8'h00 || rd_attr !== 4'd0) begin
            failures++;
            $display("FAIL scroll_blank: char=%h attr=%0d, required 00 0", rd_char, rd_attr);
        end
        read_cell(8'd14, 8'd0);
        checks++;
        if (rd_char !== 8'h70 || rd_attr !== 4'd15) begin
            failures++;
            $display("FAIL scroll_row14: char=%h attr=%0d, required 70 15", rd_char, rd_attr);
        end
        send_byte(8'h0A, 4'd0);
        read_cell(8'd0, 8'd0);
        checks++;
        if (rd_char !== 8'h63 || cursor_y !== 4'd15) begin
            failures++;
            $display("FAIL scroll_again: char=%h y=%0d, required 63 15", rd_char, cursor_y);
        end
    endtask

    task automatic test_edit;
        send_byte(8'h08, 4'd0);
        checks++;
        if (cursor_x !== 5'd0 || cursor_y !== 4'd15) begin
            failures++;
            $display("FAIL bs_at_zero: (%0d,%0d), required (15,0)", cursor_y, cursor_x);
        end
        send_byte(8'h51, 4'd9);
        read_cell(8'd15, 8'd0);
        checks++;
        if (rd_char !== 8'h51 || rd_attr !== 4'd9 || cursor_x !== 5'd1) begin
            failures++;
            $display("FAIL edit_Q: char=%h attr=%0d x=%0d, required 51 9 1", rd_char, rd_attr, cursor_x);
        end
        send_byte(8'h7F, 4'd0);
        read_cell(8'd15, 8'd0);
        checks++;
        if (rd_char !== 8'h00 || rd_attr !== 4'd0 || cursor_x !== 5'd0) begin
            failures++;
            $display("FAIL del: char=%h attr=%0d x=%0d, required 00 0 0", rd_char, rd_attr, cursor_x);
        end
        read_cell(8'd0, 8'd40);
        checks++;
        if (rd_oob !== 1'b1 || rd_char !== 8'h00 || rd_attr !== 4'd0 || rd_cursor !== 1'b0) begin
            failures++;
            $display("FAIL oob_h40: oob=%b char=%h attr=%0d cur=%b, required 1 00 0 0",
                     rd_oob, rd_char, rd_attr, rd_cursor);
        end
        read_cell(8'd0, 8'd32);
        checks++;
        if (rd_oob !== 1'b1 || rd_char !== 8'h00) begin
            failures++;
            $display("FAIL oob_h32: oob=%b char=%h, required 1 00", rd_oob, rd_char);
        end
        read_cell(8'd16, 8'd0);
        checks++;
        if (rd_oob !== 1'b1 || rd_char !== 8'h00) begin
            failures++;
            $display("FAIL oob_v16: oob=%b char=%h, required 1 00", rd_oob, rd_char);
        end
        read_cell(8'd15, 8'd31);
        checks++;
        if (rd_oob !== 1'b0) begin
            failures++;
            $display("FAIL inb_corner: oob=%b, required 0", rd_oob);
        end
    endtask

    task automatic test_esc;
        int low_cnt;
        int nz_cnt;
        send_byte(8'h1B, 4'd0);
        low_cnt = 0;
        for (int k = 0; k < 16; k++) begin
            if (in_if.in_rdy === 1'b0) low_cnt++;
            @(posedge clk);
            #1;
        end
        checks++;
        if (low_cnt != 16 || in_if.in_rdy !== 1'b1) begin
            failures++;
            $display("FAIL esc_clear_len: low cycles=%0d rdy_after=%b, required 16 and 1", low_cnt, in_if.in_rdy);
        end
        checks++;
        if (cursor_x !== 5'd0 || cursor_y !== 4'd0) begin
            failures++;
            $display("FAIL esc_cursor: (%0d,%0d), required (0,0)", cursor_y, cursor_x);
        end
        nz_cnt = 0;
        for (int r = 0; r < 16; r++) begin
            read_cell(8'(r), 8'd0);
            if (rd_char !== 8'h00 || rd_attr !== 4'd0) nz_cnt++;
        end
        checks++;
        if (nz_cnt != 0) begin
            failures++;
            $display("FAIL esc_blank: nonzero cells=%0d, required 0", nz_cnt);
        end
    endtask

    task automatic test_blink;
        logic exp;
        rd_vchar = 8'd0;
        rd_hchar = 8'd0;
        send_byte(8'h01, 4'd0);
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk);
            #1;
            exp = (((k - 1) / 4) % 2) == 0;
            checks++;
            if (rd_cursor !== exp) begin
                failures++;
                $display("FAIL blink_cycle%0d: cur=%b, required %b", k, rd_cursor, exp);
            end
        end
        send_byte(8'h01, 4'd0);
        repeat (6) @(posedge clk);
        #1;
        send_byte(8'h01, 4'd0);
        checks++;
        if (rd_cursor !== 1'b0) begin
            failures++;
            $display("FAIL blink_off_phase: cur=%b, required 0", rd_cursor);
        end
        @(posedge clk);
        #1;
        checks++;
        if (rd_cursor !== 1'b1) begin
            failures++;
            $display("FAIL blink_restart: cur=%b, required 1", rd_cursor);
        end
    endtask

    task automatic test_reset_restart;
        int low_cnt;
        send_byte(8'h5A, 4'd6);
        send_byte(8'h0A, 4'd0);
        #2 rst = 1'b1;
        #1;
        checks++;
        if (cursor_x !== 5'd0 || cursor_y !== 4'd0 || rd_oob !== 1'b1 || in_if.in_rdy !== 1'b0) begin
            failures++;
            $display("FAIL async_reset: pos=(%0d,%0d) oob=%b rdy=%b, required (0,0) 1 0",
                     cursor_y, cursor_x, rd_oob, in_if.in_rdy);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (16) @(posedge clk);
        #1;
        read_cell(8'd0, 8'd0);
        checks++;
        if (rd_char !== 8'h00 || rd_attr !== 4'd0) begin
            failures++;
            $display("FAIL reset_wipes: char=%h attr=%0d, required 00 0", rd_char, rd_attr);
        end
        send_byte(8'h1B, 4'd0);
        repeat (5) @(posedge clk);
        #2 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        low_cnt = 0;
        for (int k = 0; k < 16; k++) begin
            if (in_if.in_rdy === 1'b0) low_cnt++;
            @(posedge clk);
            #1;
        end
        checks++;
        if (low_cnt != 16 || in_if.in_rdy !== 1'b1) begin
            failures++;
            $display("FAIL midclear_restart: low cycles=%0d rdy_after=%b, required 16 and 1", low_cnt, in_if.in_rdy);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        rd_vchar = 8'd0;
        rd_hchar = 8'd0;
        in_if.in_ascii = 8'h00;
        in_if.in_attr  = 4'h0;
        in_if.in_val   = 1'b0;
        test_reset();
        test_write();
        test_wrap();
        test_scroll();
        test_edit();
        test_esc();
        test_blink();
        test_reset_restart();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
